// File: rtl/cmp_tally.sv
// Tallies comparator result codes per class and tracks runs of identical classes.
// A run of STREAK_N or more identical valid classes holds the FSM in ALARM.
module cmp_tally #(
    parameter int CNT_W    = 8,
    parameter int STREAK_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       Y,
    input  logic             clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       streak,
    output logic [1:0]       last_cls,
    output logic             alarm,
    output logic             out_valid
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ALARM} state_e;
    typedef enum logic [1:0] {CLS_NONE = 2'b00, CLS_GT = 2'b01, CLS_EQ = 2'b10, CLS_LT = 2'b11} cls_e;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       STREAK_TH = 4'(STREAK_N);

    state_e           state_q, state_d;
    cls_e             last_q, last_d, cls_new;
    logic [CNT_W-1:0] gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, err_q, err_d;
    logic [3:0]       streak_q, streak_d;
    logic             ov_q, ov_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        unique case (Y)
            3'b011:  cls_new = CLS_GT;
            3'b101:  cls_new = CLS_EQ;
            3'b110:  cls_new = CLS_LT;
            default: cls_new = CLS_NONE;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path infers a latch.
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        err_d    = err_q;
        streak_d = streak_q;
        last_d   = last_q;
        state_d  = state_q;
        ov_d     = 1'b0;

        if (clr) begin
            gt_d     = '0;
            eq_d     = '0;
            lt_d     = '0;
            err_d    = '0;
            streak_d = 4'd0;
            last_d   = CLS_NONE;
            state_d  = ST_IDLE;
        end else if (in_valid) begin
            ov_d = 1'b1;
            if (cls_new == CLS_NONE) begin
                err_d    = sat_inc(err_q);
                streak_d = 4'd0;
                last_d   = CLS_NONE;
                state_d  = ST_IDLE;
            end else begin
                unique case (cls_new)
                    CLS_GT:  gt_d = sat_inc(gt_q);
                    CLS_EQ:  eq_d = sat_inc(eq_q);
                    default: lt_d = sat_inc(lt_q);
                endcase
                // last_q is CLS_NONE after reset/clear/invalid, so it never matches here.
                if (cls_new == last_q)
                    streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
                else
                    streak_d = 4'd1;
                last_d  = cls_new;
                state_d = (streak_d >= STREAK_TH) ? ST_ALARM : ST_RUN;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments and an async reset; all state is plain flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q     <= '0;
            eq_q     <= '0;
            lt_q     <= '0;
            err_q    <= '0;
            streak_q <= 4'd0;
            last_q   <= CLS_NONE;
            state_q  <= ST_IDLE;
            ov_q     <= 1'b0;
        end else begin
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            err_q    <= err_d;
            streak_q <= streak_d;
            last_q   <= last_d;
            state_q  <= state_d;
            ov_q     <= ov_d;
        end
    end

    assign gt_cnt    = gt_q;
    assign eq_cnt    = eq_q;
    assign lt_cnt    = lt_q;
    assign err_cnt   = err_q;
    assign streak    = streak_q;
    assign last_cls  = last_q;
    assign alarm     = (state_q == ST_ALARM);
    assign out_valid = ov_q;

endmodule

// File: tb/tb_cmp_tally.sv
// Directed bench for cmp_tally: a vector table for single-cycle behaviour plus
// hand sequences for saturation and asynchronous reset.
module tb_cmp_tally;

    localparam int CNT_W    = 8;
    localparam int STREAK_N = 4;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, clr;
    logic [2:0]       y;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, err_cnt;
    logic [3:0]       streak;
    logic [1:0]       last_cls;
    logic             alarm, out_valid;

    cmp_tally #(.CNT_W(CNT_W), .STREAK_N(STREAK_N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Y(y), .clr(clr),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err_cnt(err_cnt),
        .streak(streak), .last_cls(last_cls), .alarm(alarm), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       clr, iv;
        logic [2:0] y;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Packed view: gt, eq, lt, err (8 bits each), streak(4), last_cls(2), alarm, out_valid.
    function automatic logic [39:0] pk(input logic [7:0] g, e, l, r, input logic [3:0] s,
                                       input logic [1:0] c, input logic a, o);
        return {g, e, l, r, s, c, a, o};
    endfunction

    function automatic logic [39:0] outs();
        return {gt_cnt, eq_cnt, lt_cnt, err_cnt, streak, last_cls, alarm, out_valid};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got gt/eq/lt/err=%0d/%0d/%0d/%0d st=%0d cls=%0d al=%0b ov=%0b, want gt/eq/lt/err=%0d/%0d/%0d/%0d st=%0d cls=%0d al=%0b ov=%0b",
                     name, act[39:32], act[31:24], act[23:16], act[15:8], act[7:4], act[3:2], act[1], act[0],
                     exp[39:32], exp[31:24], exp[23:16], exp[15:8], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input string name, input logic c, iv, input logic [2:0] yy, input logic [39:0] exp);
        vec_t v;
        v.name = name; v.clr = c; v.iv = iv; v.y = yy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic c, iv, input logic [2:0] yy);
        clr = c; in_valid = iv; y = yy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   name            clr iv  Y        gt eq lt err st cls al ov
        add("idle",          0, 0, 3'b000, pk(0, 0, 0, 0, 0, 0, 0, 0));
        add("gt1",           0, 1, 3'b011, pk(1, 0, 0, 0, 1, 1, 0, 1));
        add("eq1",           0, 1, 3'b101, pk(1, 1, 0, 0, 1, 2, 0, 1));
        add("lt1",           0, 1, 3'b110, pk(1, 1, 1, 0, 1, 3, 0, 1));
        add("hold",          0, 0, 3'b011, pk(1, 1, 1, 0, 1, 3, 0, 0));
        add("gt_run1",       0, 1, 3'b011, pk(2, 1, 1, 0, 1, 1, 0, 1));
        add("gt_run2",       0, 1, 3'b011, pk(3, 1, 1, 0, 2, 1, 0, 1));
        add("gt_run3",       0, 1, 3'b011, pk(4, 1, 1, 0, 3, 1, 0, 1));
        add("gt_alarm",      0, 1, 3'b011, pk(5, 1, 1, 0, 4, 1, 1, 1));
        add("gt_alarm_stay", 0, 1, 3'b011, pk(6, 1, 1, 0, 5, 1, 1, 1));
        add("alarm_to_lt",   0, 1, 3'b110, pk(6, 1, 2, 0, 1, 3, 0, 1));
        add("lt_run2",       0, 1, 3'b110, pk(6, 1, 3, 0, 2, 3, 0, 1));
        add("lt_run3",       0, 1, 3'b110, pk(6, 1, 4, 0, 3, 3, 0, 1));
        add("lt_alarm",      0, 1, 3'b110, pk(6, 1, 5, 0, 4, 3, 1, 1));
        add("err_111",       0, 1, 3'b111, pk(6, 1, 5, 1, 0, 0, 0, 1));
        add("err_000",       0, 1, 3'b000, pk(6, 1, 5, 2, 0, 0, 0, 1));
        add("idle_to_eq",    0, 1, 3'b101, pk(6, 2, 5, 2, 1, 2, 0, 1));
        add("clr_beats_iv",  1, 1, 3'b011, pk(0, 0, 0, 0, 0, 0, 0, 0));
        add("after_clr",     0, 0, 3'b011, pk(0, 0, 0, 0, 0, 0, 0, 0));
        add("err_100",       0, 1, 3'b100, pk(0, 0, 0, 1, 0, 0, 0, 1));
        add("err_010",       0, 1, 3'b010, pk(0, 0, 0, 2, 0, 0, 0, 1));
        add("err_001",       0, 1, 3'b001, pk(0, 0, 0, 3, 0, 0, 0, 1));
        add("lt_after_err",  0, 1, 3'b110, pk(0, 0, 1, 3, 1, 3, 0, 1));
        add("clr_only",      1, 0, 3'b000, pk(0, 0, 0, 0, 0, 0, 0, 0));

        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; y = 3'b000;
        #1;
        check("reset_state", outs(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].clr, vecs[i].iv, vecs[i].y);
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // 300 consecutive EQ samples: counter saturates at 255, streak at 15.
        for (int i = 1; i <= 300; i++) begin
            apply(1'b0, 1'b1, 3'b101);
            if (i == 20)
                check("eq_streak_cap", outs(), pk(0, 20, 0, 0, 15, 2, 1, 1));
        end
        check("eq_sat_300", outs(), pk(0, 255, 0, 0, 15, 2, 1, 1));
        apply(1'b0, 0, 3'b101);
        check("eq_sat_hold", outs(), pk(0, 255, 0, 0, 15, 2, 1, 0));

        // Asynchronous reset between clock edges while a sample is presented.
        apply(1'b0, 1'b1, 3'b011);
        check("pre_reset", outs(), pk(1, 255, 0, 0, 1, 1, 0, 1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("reset_discard", outs(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", outs(), pk(1, 0, 0, 0, 1, 1, 0, 1));
        apply(1'b0, 1'b0, 3'b000);
        check("pulse_end", outs(), pk(1, 0, 0, 0, 1, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmp_tally.md
CMP_TALLY -- requirements
Module: cmp_tally

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of each class counter.
REQ-002 SHALL have parameter STREAK_N, default 4, giving the number of consecutive same-class results that raises alarm; legal range 2..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning Y carries a comparator result this cycle.
REQ-006 SHALL have port Y, input, 3, the comparator code: 3'b011 = A>B (GT), 3'b101 = A==B (EQ), 3'b110 = A<B (LT); every other value is an invalid code.
REQ-007 SHALL have port clr, input, 1, a synchronous clear of all tallies.
REQ-008 SHALL have port gt_cnt, output, CNT_W, the number of accepted GT results.
REQ-009 SHALL have port eq_cnt, output, CNT_W, the number of accepted EQ results.
REQ-010 SHALL have port lt_cnt, output, CNT_W, the number of accepted LT results.
REQ-011 SHALL have port err_cnt, output, CNT_W, the number of accepted invalid codes.
REQ-012 SHALL have port streak, output, 4, the length of the current run of identical valid classes.
REQ-013 SHALL have port last_cls, output, 2, the class of the last accepted sample: 00 none, 01 GT, 10 EQ, 11 LT.
REQ-014 SHALL have port alarm, output, 1, high while the FSM is in ALARM.
REQ-015 SHALL have port out_valid, output, 1, a one-cycle pulse meaning the outputs reflect a newly accepted sample.

Function
REQ-016 SHALL accept a sample on any rising edge where in_valid=1 and clr=0; there is no backpressure.
REQ-017 SHALL register all outputs, so their values update on the edge that accepts the sample (1-cycle latency).
REQ-018 SHALL assert out_valid for exactly the cycle following each accepted sample; back-to-back samples give a continuous high.
REQ-019 SHALL increment the matching counter by 1 on each accepted valid code, and SHALL hold it at 2^CNT_W-1 (no wrap).
REQ-020 SHALL increment err_cnt on each accepted invalid code, saturating the same way.
REQ-021 SHALL set streak to min(streak+1,15) when a valid code matches last_cls; otherwise to 1. last_cls SHALL take the new class.
REQ-022 SHALL, on an invalid code, set streak=0 and last_cls=00, and the FSM SHALL go to IDLE.
REQ-023 SHALL implement the FSM states IDLE (no valid class held), RUN (streak < STREAK_N) and ALARM (streak >= STREAK_N).
REQ-024 SHALL make the following FSM transitions:
- IDLE: valid code -> RUN (streak=1).
- RUN: the updated streak reaching STREAK_N -> ALARM.
- ALARM: same class -> stay in ALARM; different valid class -> RUN (streak=1).
- Any state: invalid code -> IDLE.
REQ-025 SHALL hold all state while in_valid=0.
REQ-026 SHALL, when clr=1, zero all counters, streak, last_cls and out_valid and go to IDLE on that edge; clr SHALL override a simultaneous in_valid, and the sample is discarded.
REQ-027 SHALL drive alarm purely from the FSM state (alarm = state==ALARM).

Reset
REQ-028 SHALL, while rst_n=0, immediately force all counters=0, streak=0, last_cls=00, alarm=0, out_valid=0 and FSM=IDLE, independent of clk.
REQ-029 SHALL, when reset is asserted mid-stream, discard any sample being presented; the first edge with rst_n=1 and in_valid=1 is accepted normally.

Verification
REQ-030 SHALL be verified by this scenario: reset, then Y=011,101,110 on three cycles -> gt/eq/lt_cnt=1 each, streak=1, last_cls=11, alarm=0, out_valid high 3 cycles.
REQ-031 SHALL be verified by this scenario: STREAK_N=4, Y=011 x4 -> alarm rises on the 4th accept edge, streak=4; then Y=110 -> alarm=0, streak=1, last_cls=11.
REQ-032 SHALL be verified by this scenario: Y=111 and Y=000 during ALARM -> err_cnt=2, streak=0, last_cls=00, alarm=0, FSM IDLE.
REQ-033 SHALL be verified by this scenario: CNT_W=8, Y=101 x300 -> eq_cnt=255 and streak=15 held.
REQ-034 SHALL be verified by this scenario: clr=1 with in_valid=1, Y=011 -> all outputs 0 next cycle, gt_cnt stays 0.
REQ-035 SHALL be verified by this scenario: rst_n pulled low between clock edges mid-run -> outputs 0 asynchronously, before the next edge.
